mul_seq_radix: RTL

Parametrised iterative integer multiplier for the execute-stage mul/div unit. It implements all four RV32M/RV64M multiply ops: MUL, MULH, MULHSU and MULHU. It retires RADIX_BITS multiplier bits per cycle and handles signed operands by magnitude/sign correction. It also provides a zero-operand early-out and a pipeline-flush kill. It replaces the fixed 32-bit, unsigned-only, 1-bit-per-cycle sequential multiplier.

---
 rtl/mul_seq_radix.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mul_seq_radix.sv
// mul_seq_radix
// Iterative RV32M/RV64M integer multiplier (MUL, MULH, MULHSU, MULHU).
// The operands are reduced to unsigned magnitudes when they are accepted.
// Each CALC cycle then retires RADIX_BITS multiplier bits.
// The FIX cycle applies the sign correction and selects the result half.
//
// Ports:
//   clk_i      clock, rising edge
//   rst_i      asynchronous active-high reset
//   start_i    request; accepted only in IDLE when kill_i=0
//   kill_i     synchronous abort (pipeline flush); overrides start_i
//   op_i       00=MUL 01=MULH 10=MULHSU 11=MULHU, sampled at accept
//   rs1_i      multiplicand, sampled at accept
//   rs2_i      multiplier, sampled at accept
//   result_o   architectural result (low half for MUL, high half otherwise)
//   product_o  full 2*XLEN signed-corrected product
//   busy_o     operation in flight (CALC or FIX)
//   done_o     one-cycle pulse when result_o/product_o update
module mul_seq_radix #(
    parameter int XLEN       = 32,
    parameter int RADIX_BITS = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              kill_i,
    input  logic [1:0]        op_i,
    input  logic [XLEN-1:0]   rs1_i,
    input  logic [XLEN-1:0]   rs2_i,
    output logic [XLEN-1:0]   result_o,
    output logic [2*XLEN-1:0] product_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int N     = XLEN / RADIX_BITS;
    localparam int PW    = 2 * XLEN;
    localparam int CNT_W = $clog2(N) + 1;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [PW-1:0]     mag_a_q, mag_a_d;     // multiplicand, pre-shifted by the digit weight
    logic [XLEN-1:0]   mag_b_q, mag_b_d;     // multiplier, consumed LSB-first
    logic              neg_q, neg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [PW-1:0]     product_q, product_d;
    logic              done_q, done_d;

    // Partial product for the current digit: one shifted multiplicand per digit bit.
    logic [PW-1:0]     term [RADIX_BITS];
    logic [PW-1:0]     partial;

    generate
        for (genvar gi = 0; gi < RADIX_BITS; gi++) begin : g_term
            assign term[gi] = mag_b_q[gi] ? (mag_a_q << gi) : '0;
        end
    endgenerate

    always_comb begin
        partial = '0;
        for (int i = 0; i < RADIX_BITS; i++) begin
            partial = partial + term[i];
        end
    end

    // Accept-time operand conditioning
    logic            sign_a, sign_b;
    logic [XLEN-1:0] mag_a_in, mag_b_in;
    logic [PW-1:0]   prod_fix;

    assign sign_a   = rs1_i[XLEN-1] & (op_i != OP_MULHU);
    assign sign_b   = rs2_i[XLEN-1] & ~op_i[1];
    // The magnitude of the most negative value wraps to 2^(XLEN-1).
    // That is the correct unsigned magnitude.
    assign mag_a_in = sign_a ? -rs1_i : rs1_i;
    assign mag_b_in = sign_b ? -rs2_i : rs2_i;
    // An accumulator of zero negates to zero, so neg=1 cannot produce -0.
    assign prod_fix = neg_q ? -acc_q : acc_q;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        mag_a_d   = mag_a_q;
        mag_b_d   = mag_b_q;
        neg_d     = neg_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        result_d  = result_q;
        product_d = product_q;
        done_d    = 1'b0;

        if (kill_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        op_d    = op_i;
                        mag_a_d = {{XLEN{1'b0}}, mag_a_in};
                        mag_b_d = mag_b_in;
                        neg_d   = sign_a ^ sign_b;
                        cnt_d   = '0;
                        acc_d   = '0;
                        state_d = (mag_a_in == '0 || mag_b_in == '0) ? S_FIX : S_CALC;
                    end
                end
                S_CALC: begin
                    acc_d   = acc_q + partial;
                    mag_a_d = mag_a_q << RADIX_BITS;
                    mag_b_d = mag_b_q >> RADIX_BITS;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(N - 1)) begin
                        state_d = S_FIX;
                    end
                end
                S_FIX: begin
                    product_d = prod_fix;
                    result_d  = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[PW-1:XLEN];
                    done_d    = 1'b1;
                    state_d   = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            mag_a_q   <= '0;
            mag_b_q   <= '0;
            neg_q     <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            result_q  <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            mag_a_q   <= mag_a_d;
            mag_b_q   <= mag_b_d;
            neg_q     <= neg_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    assign result_o  = result_q;
    assign product_o = product_q;
    assign busy_o    = (state_q != S_IDLE);
    assign done_o    = done_q;

endmodule
